// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the JZJCoreF fetch/execute sequencer.
// Holds the FSM state encoding and the target-alignment helper.
package JZJCoreFTypes;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      EXECUTE = 2'd1,
      HALT    = 2'd2
   } FetchState_t;

   localparam logic [31:0] INSTRUCTION_RESET = 32'h00000000;

   // Instructions are word aligned; any low bit set in a branch target is fatal.
   function automatic logic isMisaligned(input logic [1:0] targetLow);
      return targetLow != 2'b00;
   endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Program counter and fetch/execute sequencer for JZJCoreF.
// Fetches at PC, presents the word for one execute cycle, then loads the BranchALU target.
module fetch_sequencer
   import JZJCoreFTypes::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] programCounterInput,
   input  logic        branchALUBadFunct3,
   input  logic        decodeError,
   output logic [31:0] imemAddress,
   output logic        imemRequest,
   input  logic        imemReady,
   input  logic [31:0] imemInstruction,
   output logic [31:0] pcOfInstruction,
   output logic [31:0] instruction,
   output logic        instructionValid,
   output logic        halted,
   output logic        misalignedTarget,
   output logic [31:0] instructionsRetired
);

   FetchState_t state;
   logic [31:0] programCounter;
   logic [31:0] instructionWord;
   logic [31:0] retiredCount;
   logic        misalignedSticky;
   logic        targetMisaligned;
   logic        executeError;

   assign targetMisaligned = isMisaligned(programCounterInput[1:0]);
   assign executeError     = branchALUBadFunct3 | decodeError | targetMisaligned;

   // Request is gated by reset so it drops the moment reset asserts, even mid-fetch.
   assign imemRequest         = (state == FETCH) & reset;
   assign imemAddress         = programCounter;
   assign pcOfInstruction     = programCounter;
   assign instruction         = instructionWord;
   assign instructionValid    = (state == EXECUTE);
   assign halted              = (state == HALT);
   assign misalignedTarget    = misalignedSticky;
   assign instructionsRetired = retiredCount;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= FETCH;
         programCounter   <= RESET_VECTOR;
         instructionWord  <= INSTRUCTION_RESET;
         retiredCount     <= 32'h00000000;
         misalignedSticky <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (imemReady) begin
                  instructionWord <= imemInstruction;
                  state           <= EXECUTE;
               end
            end
            EXECUTE: begin
               // A faulting instruction does not retire; PC keeps pointing at it for debug.
               if (executeError) begin
                  misalignedSticky <= targetMisaligned;
                  state            <= HALT;
               end else begin
                  programCounter <= programCounterInput;
                  retiredCount   <= retiredCount + 32'd1;
                  state          <= FETCH;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= HALT;
            end
         endcase
      end
   end

endmodule
